// File: rtl/color_pkg.sv
// Shared color types used by the rasterizer front end.
// color12_t packs 4 bits each of R, G and B.
package color_pkg;

  typedef logic [11:0] color12_t;

endpackage

// File: rtl/math_pkg.sv
// Shared fixed-point arithmetic types.
// q16_16_t is a signed value with 16 integer bits and 16 fractional bits.
package math_pkg;

  typedef logic signed [31:0] q16_16_t;

endpackage

// File: rtl/rasterizer_pkg.sv
// Triangle setup descriptor shared by the rasterizer stages.
// Traversal scans the integer pixel bbox; the remaining fields travel with each pixel.
package rasterizer_pkg;

  import color_pkg::*;
  import math_pkg::*;

  localparam int RAST_SUBPIXEL_BITS  = 4;
  localparam int RAST_DENOM_INV_BITS = 36;
  localparam int COORD_INT_BITS      = 12;
  localparam int BBOX_BITS           = 16;

  typedef logic signed [COORD_INT_BITS+RAST_SUBPIXEL_BITS-1:0] fixed_coord_t;

  typedef struct packed {
    fixed_coord_t                         v0x;
    fixed_coord_t                         v0y;
    fixed_coord_t                         e0x;
    fixed_coord_t                         e0y;
    fixed_coord_t                         e1x;
    fixed_coord_t                         e1y;
    logic signed [RAST_DENOM_INV_BITS-1:0] denom_inv;
    logic [BBOX_BITS-1:0]                 bbox_min_x;
    logic [BBOX_BITS-1:0]                 bbox_min_y;
    logic [BBOX_BITS-1:0]                 bbox_max_x;
    logic [BBOX_BITS-1:0]                 bbox_max_y;
    color12_t                             v0_color;
    color12_t                             v1_color;
    color12_t                             v2_color;
    q16_16_t                              v0_depth;
    q16_16_t                              v1_depth;
    q16_16_t                              v2_depth;
  } triangle_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } trav_state_e;

endpackage

// File: rtl/pixel_traversal.sv
// Walks the screen-clamped bounding box of one triangle in raster order,
// emitting one pixel per downstream handshake.
module pixel_traversal
  import rasterizer_pkg::*;
#(
  parameter int WIDTH          = 320,
  parameter int HEIGHT         = 240,
  parameter int SUBPIXEL_BITS  = 4,
  parameter int DENOM_INV_BITS = 36
) (
  input  logic                      clk,
  input  logic                      rst,
  input  triangle_t                 tri_in,
  input  logic                      tri_valid,
  output logic                      tri_ready,
  output logic [$clog2(WIDTH)-1:0]  out_x,
  output logic [$clog2(HEIGHT)-1:0] out_y,
  output triangle_t                 out_tri,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      tri_done,
  output logic                      busy
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [BBOX_BITS-1:0] LAST_X = BBOX_BITS'(WIDTH - 1);
  localparam logic [BBOX_BITS-1:0] LAST_Y = BBOX_BITS'(HEIGHT - 1);

  if (SUBPIXEL_BITS != RAST_SUBPIXEL_BITS || DENOM_INV_BITS != RAST_DENOM_INV_BITS) begin : g_bad_fmt
    $error("pixel_traversal: fixed-point widths must match rasterizer_pkg");
  end

  trav_state_e   state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  triangle_t     tri_q, tri_d, clamp_s;
  logic          out_valid_q, out_valid_d;
  logic          tri_done_q, tri_done_d;
  logic          drop_s;

  // Clamp the incoming bbox to the screen and flag triangles with nothing to draw.
  always_comb begin
    clamp_s = tri_in;
    if (tri_in.bbox_max_x > LAST_X) begin
      clamp_s.bbox_max_x = LAST_X;
    end else begin
      clamp_s.bbox_max_x = tri_in.bbox_max_x;
    end
    if (tri_in.bbox_max_y > LAST_Y) begin
      clamp_s.bbox_max_y = LAST_Y;
    end else begin
      clamp_s.bbox_max_y = tri_in.bbox_max_y;
    end
    drop_s = (clamp_s.bbox_min_x > clamp_s.bbox_max_x) ||
             (clamp_s.bbox_min_y > clamp_s.bbox_max_y) ||
             (tri_in.denom_inv == {DENOM_INV_BITS{1'b0}});
  end

  // Next-state logic for acceptance, raster stepping and completion.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    tri_d       = tri_q;
    out_valid_d = out_valid_q;
    tri_done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        out_valid_d = 1'b0;
        if (tri_valid) begin
          tri_d = clamp_s;
          if (drop_s) begin
            tri_done_d = 1'b1;
          end else begin
            // min <= clamped max <= screen edge, so the low bits hold the full value.
            state_d     = ST_SCAN;
            out_valid_d = 1'b1;
            x_d         = clamp_s.bbox_min_x[XW-1:0];
            y_d         = clamp_s.bbox_min_y[YW-1:0];
          end
        end else begin
          tri_d = tri_q;
        end
      end
      ST_SCAN: begin
        if (out_ready) begin
          if (x_q == tri_q.bbox_max_x[XW-1:0]) begin
            x_d = tri_q.bbox_min_x[XW-1:0];
            if (y_q == tri_q.bbox_max_y[YW-1:0]) begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
              tri_done_d  = 1'b1;
            end else begin
              y_d = y_q + YW'(1'b1);
            end
          end else begin
            x_d = x_q + XW'(1'b1);
          end
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      tri_q       <= '0;
      out_valid_q <= 1'b0;
      tri_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      tri_q       <= tri_d;
      out_valid_q <= out_valid_d;
      tri_done_q  <= tri_done_d;
    end
  end

  assign tri_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_tri   = tri_q;
  assign out_valid = out_valid_q;
  assign tri_done  = tri_done_q;

endmodule

// File: tb/tb_pixel_traversal.sv
// Scoreboard bench for pixel_traversal: expected pixels are queued when a
// triangle is sent and checked in order as the DUT hands them over.
`timescale 1ns/1ps
module tb_pixel_traversal;
  import rasterizer_pkg::*;

  localparam int W  = 320;
  localparam int H  = 240;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst;
  triangle_t     tri_in;
  logic          tri_valid;
  logic          tri_ready;
  logic [XW-1:0] out_x;
  logic [YW-1:0] out_y;
  triangle_t     out_tri;
  logic          out_valid;
  logic          out_ready;
  logic          tri_done;
  logic          busy;

  pix_t      exp_q[$];
  triangle_t exp_tri;
  int        n_vec = 0;
  int        n_err = 0;

  always #5 clk = ~clk;

  pixel_traversal #(.WIDTH(W), .HEIGHT(H), .SUBPIXEL_BITS(4), .DENOM_INV_BITS(36)) dut (
    .clk(clk), .rst(rst), .tri_in(tri_in), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .out_x(out_x), .out_y(out_y), .out_tri(out_tri), .out_valid(out_valid),
    .out_ready(out_ready), .tri_done(tri_done), .busy(busy)
  );

  function automatic triangle_t make_tri(input int mnx, input int mny, input int mxx, input int mxy,
                                         input logic [35:0] dinv);
    triangle_t t;
    t = '0;
    t.v0x = 16'sd1600;  t.v0y = 16'sd800;
    t.e0x = 16'sd64;    t.e0y = -16'sd32;
    t.e1x = -16'sd16;   t.e1y = 16'sd48;
    t.denom_inv  = dinv;
    t.bbox_min_x = 16'(mnx); t.bbox_min_y = 16'(mny);
    t.bbox_max_x = 16'(mxx); t.bbox_max_y = 16'(mxy);
    t.v0_color = 12'hf00; t.v1_color = 12'h0f0; t.v2_color = 12'h00f;
    t.v0_depth = 32'h0001_8000; t.v1_depth = 32'h0002_0000; t.v2_depth = 32'h0000_4000;
    return t;
  endfunction

  // Reference traversal: clamp, then list every pixel of the bbox in raster order.
  task automatic model_push(input triangle_t t);
    int mxx, mxy;
    mxx = (int'(t.bbox_max_x) > W - 1) ? W - 1 : int'(t.bbox_max_x);
    mxy = (int'(t.bbox_max_y) > H - 1) ? H - 1 : int'(t.bbox_max_y);
    exp_tri = t;
    exp_tri.bbox_max_x = 16'(mxx);
    exp_tri.bbox_max_y = 16'(mxy);
    if (int'(t.bbox_min_x) <= mxx && int'(t.bbox_min_y) <= mxy && t.denom_inv != 36'd0) begin
      for (int y = int'(t.bbox_min_y); y <= mxy; y++)
        for (int x = int'(t.bbox_min_x); x <= mxx; x++)
          exp_q.push_back('{x: XW'(x), y: YW'(y)});
    end
  endtask

  task automatic send_tri(input triangle_t t);
    n_vec++;
    if (tri_ready !== 1'b1) begin
      n_err++; $display("FAIL tri_ready_idle: got %b, expected 1", tri_ready);
    end
    tri_in = t; tri_valid = 1'b1;
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  // mode 0: ready always high, 1: pattern 1,0,0 repeating, 2: random
  task automatic drain(input int mode, input int budget, output int hs, output int cycles);
    int cyc; bit done; bit pv; bit pr; pix_t pp; triangle_t pt;
    cyc = 0; done = 1'b0; pv = 1'b0; pr = 1'b0; pp = '0; pt = '0; hs = 0;
    while ((exp_q.size() != 0 || !done) && cyc < budget) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 3 == 0);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (pv && !pr) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_x !== pp.x || out_y !== pp.y || out_tri !== pt) begin
          n_err++;
          $display("FAIL stall_hold: got v=%b (%0d,%0d), expected v=1 (%0d,%0d) unchanged",
                   out_valid, out_x, out_y, pp.x, pp.y);
        end
      end
      if (out_valid === 1'b1) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL extra_pixel: got (%0d,%0d), expected none", out_x, out_y);
        end else if (out_x !== exp_q[0].x || out_y !== exp_q[0].y) begin
          n_err++;
          $display("FAIL pixel_order: got (%0d,%0d), expected (%0d,%0d)",
                   out_x, out_y, exp_q[0].x, exp_q[0].y);
        end
        n_vec++;
        if (out_tri !== exp_tri || busy !== 1'b1 || tri_ready !== 1'b0) begin
          n_err++;
          $display("FAIL scan_state: got max=(%0d,%0d) busy=%b rdy=%b, expected max=(%0d,%0d) busy=1 rdy=0",
                   out_tri.bbox_max_x, out_tri.bbox_max_y, busy, tri_ready,
                   exp_tri.bbox_max_x, exp_tri.bbox_max_y);
        end
        if (out_ready && exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          hs++;
        end
      end
      if (tri_done === 1'b1) begin
        done = 1'b1;
        n_vec++;
        if (exp_q.size() != 0 || tri_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
          n_err++;
          $display("FAIL done_state: got left=%0d rdy=%b busy=%b v=%b, expected left=0 rdy=1 busy=0 v=0",
                   exp_q.size(), tri_ready, busy, out_valid);
        end
      end
      pv = (out_valid === 1'b1); pr = out_ready;
      pp = '{x: out_x, y: out_y}; pt = out_tri;
      @(negedge clk);
      cyc++;
    end
    cycles = cyc;
    n_vec++;
    if (!done || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL timeout: got done=%b left=%0d after %0d cycles, expected done=1 left=0",
               done, exp_q.size(), cyc);
    end
    exp_q.delete();
    n_vec++;
    if (tri_done !== 1'b0) begin
      n_err++; $display("FAIL done_pulse_width: got %b, expected 0", tri_done);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || tri_done !== 1'b0 || out_x !== '0 || out_y !== '0 ||
        out_tri !== '0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_values: got v=%b done=%b x=%0d y=%0d busy=%b, expected all 0",
               out_valid, tri_done, out_x, out_y, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (tri_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got rdy=%b busy=%b v=%b, expected 1 0 0", tri_ready, busy, out_valid);
    end
  endtask

  task automatic test_basic();
    int hs, cyc;
    exp_tri = make_tri(10, 20, 11, 21, 36'd12345);
    exp_q.push_back('{x: 9'd10, y: 8'd20}); exp_q.push_back('{x: 9'd11, y: 8'd20});
    exp_q.push_back('{x: 9'd10, y: 8'd21}); exp_q.push_back('{x: 9'd11, y: 8'd21});
    send_tri(exp_tri);
    drain(0, 50, hs, cyc);
    n_vec++;
    if (hs != 4 || cyc != 5) begin
      n_err++; $display("FAIL basic_timing: got hs=%0d cycles=%0d, expected hs=4 cycles=5", hs, cyc);
    end
  endtask

  task automatic test_stall();
    int hs, cyc;
    triangle_t t;
    t = make_tri(10, 20, 11, 21, 36'd777);
    model_push(t);
    send_tri(t);
    drain(1, 80, hs, cyc);
    n_vec++;
    if (hs != 4 || cyc != 11) begin
      n_err++; $display("FAIL stall_handshakes: got hs=%0d cycles=%0d, expected hs=4 cycles=11", hs, cyc);
    end
  endtask

  task automatic test_drop();
    int hs, cyc;
    triangle_t t;
    for (int k = 0; k < 2; k++) begin
      t = (k == 0) ? make_tri(5, 3, 4, 6, 36'd99) : make_tri(2, 2, 3, 3, 36'd0);
      model_push(t);
      send_tri(t);
      drain(0, 20, hs, cyc);
      n_vec++;
      if (hs != 0 || cyc != 1 || tri_ready !== 1'b1) begin
        n_err++;
        $display("FAIL drop_%0d: got hs=%0d cycles=%0d rdy=%b, expected hs=0 cycles=1 rdy=1",
                 k, hs, cyc, tri_ready);
      end
    end
  endtask

  task automatic test_clamp();
    int hs, cyc;
    triangle_t t;
    t = make_tri(318, 239, 400, 300, 36'd4242);
    exp_tri = t;
    exp_tri.bbox_max_x = 16'd319;
    exp_tri.bbox_max_y = 16'd239;
    exp_q.push_back('{x: 9'd318, y: 8'd239});
    exp_q.push_back('{x: 9'd319, y: 8'd239});
    send_tri(t);
    n_vec++;
    if (out_tri.bbox_max_x !== 16'd319 || out_tri.bbox_max_y !== 16'd239) begin
      n_err++;
      $display("FAIL clamp_bbox: got max=(%0d,%0d), expected (319,239)",
               out_tri.bbox_max_x, out_tri.bbox_max_y);
    end
    drain(0, 50, hs, cyc);
    n_vec++;
    if (hs != 2) begin
      n_err++; $display("FAIL clamp_count: got %0d pixels, expected 2", hs);
    end
  endtask

  task automatic test_back_to_back();
    int hs, cyc;
    triangle_t t1, t2;
    t1 = make_tri(0, 0, 0, 0, 36'd5);
    t2 = make_tri(30, 40, 32, 41, 36'd6);
    exp_tri = t1;
    send_tri(t1);
    tri_in = t2; tri_valid = 1'b1; out_ready = 1'b1;
    n_vec++;
    if (out_valid !== 1'b1 || out_x !== 9'd0 || out_y !== 8'd0 || out_tri !== t1) begin
      n_err++;
      $display("FAIL b2b_first: got v=%b (%0d,%0d), expected v=1 (0,0)", out_valid, out_x, out_y);
    end
    @(negedge clk);
    n_vec++;
    if (tri_done !== 1'b1 || tri_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_done: got done=%b rdy=%b v=%b, expected 1 1 0", tri_done, tri_ready, out_valid);
    end
    @(negedge clk);
    tri_valid = 1'b0;
    model_push(t2);
    drain(0, 50, hs, cyc);
    n_vec++;
    if (hs != 6 || cyc != 7) begin
      n_err++; $display("FAIL b2b_second: got hs=%0d cycles=%0d, expected hs=6 cycles=7", hs, cyc);
    end
  endtask

  task automatic test_reset_mid_scan();
    int hs, cyc;
    triangle_t t;
    t = make_tri(4, 4, 7, 7, 36'd31);
    model_push(t);
    send_tri(t);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_x !== exp_q[0].x || out_y !== exp_q[0].y) begin
        n_err++;
        $display("FAIL abort_pre_%0d: got v=%b (%0d,%0d), expected v=1 (%0d,%0d)",
                 i, out_valid, out_x, out_y, exp_q[0].x, exp_q[0].y);
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || tri_done !== 1'b0 || tri_ready !== 1'b1) begin
      n_err++;
      $display("FAIL abort_now: got v=%b busy=%b done=%b rdy=%b, expected 0 0 0 1",
               out_valid, busy, tri_done, tri_ready);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++;
      if (tri_done !== 1'b0 || out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL abort_quiet_%0d: got done=%b v=%b, expected 0 0", i, tri_done, out_valid);
      end
    end
    t = make_tri(1, 2, 2, 3, 36'd17);
    model_push(t);
    send_tri(t);
    drain(0, 50, hs, cyc);
    n_vec++;
    if (hs != 4) begin
      n_err++; $display("FAIL abort_next: got %0d pixels, expected 4", hs);
    end
  endtask

  task automatic test_random();
    int hs, cyc, mnx, mny;
    triangle_t t;
    for (int k = 0; k < 8; k++) begin
      mnx = $urandom_range(1, 325);
      mny = $urandom_range(1, 245);
      t = make_tri(mnx, mny, mnx + $urandom_range(0, 6) - 1, mny + $urandom_range(0, 5) - 1,
                   36'($urandom_range(0, 3)));
      model_push(t);
      send_tri(t);
      drain(2, 600, hs, cyc);
    end
  endtask

  initial begin
    rst = 1'b1; tri_valid = 1'b0; out_ready = 1'b0; tri_in = '0; exp_tri = '0;
    test_reset();
    test_basic();
    test_stall();
    test_drop();
    test_clamp();
    test_back_to_back();
    test_reset_mid_scan();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
